display_scan_controller: RTL and testbench

Time-multiplexing controller for the board's four-digit common-anode seven-segment display. It holds a 16-bit hex value and scans it onto the shared `seg7` bus one digit at a time, driving the anode enables. Each digit slot begins with a blanking interval to suppress ghosting. New values are taken through a load/ack handshake and applied only at frame boundaries, so a frame never shows a torn value. It sits between the train-controller state logic and the display pins.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/hex_to_seg7.sv | 31 +++
 rtl/display_scan_controller.sv | 167 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// active-low segment codes, anode idle pattern, phase enum and display word.
package display_pkg;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_e;

    // Value plus per-digit decimal points, always moved as one unit.
    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dots;
    } disp_word_t;

    // Active-low anode pattern with only the selected digit enabled.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment {g,f,e,d,c,b,a} decoder.
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (hex)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit common-anode seven-segment scanner with per-slot blanking and a
// load/ack handshake that only swaps the shown value at frame boundaries.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  digit_en,
    output logic        ack,
    output logic [3:0]  an,
    output logic [6:0]  seg7,
    output logic        dp
);

    localparam int unsigned    CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    phase_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;

    disp_word_t         shown_q, shown_d;
    disp_word_t         pend_word_q, pend_word_d;
    logic               pend_q, pend_d;
    logic               ack_q, ack_d;

    logic [3:0]         an_q, an_d;
    logic [6:0]         seg7_q, seg7_d;
    logic               dp_q, dp_d;

    logic               slot_end_c;
    logic               frame_end_c;
    logic [3:0]         nibble_c;
    logic [6:0]         seg_dec_c;
    disp_word_t         load_word_c;

    assign slot_end_c  = (cnt_q == CNT_LAST);
    assign frame_end_c = slot_end_c && (idx_q == 2'd3);

    // State register: phase, slot counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: the phase tracks the counter so BLANK always leads a slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (slot_end_c) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake: a load at the boundary bypasses the pending slot; otherwise the latest load waits.
    always_comb begin
        load_word_c.val  = value;
        load_word_c.dots = dp_mask;
        shown_d          = shown_q;
        pend_word_d      = pend_word_q;
        pend_d           = pend_q;
        ack_d            = 1'b0;
        if (frame_end_c) begin
            if (load) begin
                shown_d = load_word_c;
                pend_d  = 1'b0;
                ack_d   = 1'b1;
            end else if (pend_q) begin
                shown_d = pend_word_q;
                pend_d  = 1'b0;
                ack_d   = 1'b1;
            end
        end else if (load) begin
            pend_word_d = load_word_c;
            pend_d      = 1'b1;
        end
    end

    always_comb begin
        nibble_c = shown_q.val[3:0];
        case (idx_q)
            2'd0: nibble_c = shown_q.val[3:0];
            2'd1: nibble_c = shown_q.val[7:4];
            2'd2: nibble_c = shown_q.val[11:8];
            2'd3: nibble_c = shown_q.val[15:12];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex   (nibble_c),
        .seg_c (seg_dec_c)
    );

    // Output decode: a disabled digit still consumes its slot but stays dark.
    always_comb begin
        an_d   = AN_OFF;
        seg7_d = SEG_OFF;
        dp_d   = 1'b1;
        if ((state_q == DRIVE) && digit_en[idx_q]) begin
            an_d   = an_select(idx_q);
            seg7_d = seg_dec_c;
            dp_d   = ~shown_q.dots[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shown_q     <= '0;
            pend_word_q <= '0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            shown_q     <= shown_d;
            pend_word_q <= pend_word_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q   <= AN_OFF;
            seg7_q <= SEG_OFF;
            dp_q   <= 1'b1;
        end else begin
            an_q   <= an_d;
            seg7_q <= seg7_d;
            dp_q   <= dp_d;
        end
    end

    assign ack  = ack_q;
    assign an   = an_q;
    assign seg7 = seg7_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_display_scan_controller;

    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;
    localparam int FRAME = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_en;
    logic        ack;
    logic [3:0]  an;
    logic [6:0]  seg7;
    logic        dp;

    display_scan_controller #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .dp_mask  (dp_mask),
        .digit_en (digit_en),
        .ack      (ack),
        .an       (an),
        .seg7     (seg7),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpm;
        int          ack_cyc;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] cur_val  = '0;
    logic [3:0]  cur_dp   = '0;

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected {an, seg7, dp} sampled after edge c (c counts edges since reset release).
    function automatic logic [11:0] model_out(input int c, input logic [15:0] v,
                                              input logic [3:0] dpm, input logic [3:0] en);
        int p, d, pos;
        logic [3:0] an_e;
        logic [15:0] sh;
        p   = (c - 1) % FRAME;
        d   = p / 8;
        pos = p % 8;
        if (c == 0 || pos < int'(BC) || !en[d]) return {4'hF, 7'h7F, 1'b1};
        an_e    = 4'hF;
        an_e[d] = 1'b0;
        sh      = v >> (4 * d);
        return {an_e, ref_seg(sh[3:0]), ~dpm[d]};
    endfunction

    // Scoreboard monitor: per-cycle output model and ack pop/compare.
    always @(posedge clk) begin
        logic [3:0]  en_s;
        logic        rst_s;
        logic [11:0] exp_o;
        sb_t         e;
        en_s  = digit_en;
        rst_s = rst;
        if (rst_s) cyc = 0;
        else       cyc = cyc + 1;
        #1;
        exp_o = rst_s ? {4'hF, 7'h7F, 1'b1} : model_out(cyc, cur_val, cur_dp, en_s);
        n_checks++;
        if ({an, seg7, dp} !== exp_o) begin
            n_fail++;
            $display("FAIL scan_out cyc=%0d: got an=%b seg7=%b dp=%b, expected an=%b seg7=%b dp=%b",
                     cyc, an, seg7, dp, exp_o[11:8], exp_o[7:1], exp_o[0]);
        end
        if (rst_s) begin
            n_checks++;
            if (ack !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_in_reset: got ack=%b, expected 0", ack);
            end
            sb.delete();
            cur_val = '0;
            cur_dp  = '0;
        end else if (ack === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_ack cyc=%0d: got ack=1 with nothing pending, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                if (e.ack_cyc != cyc) begin
                    n_fail++;
                    $display("FAIL ack_timing: got ack at cyc=%0d, expected cyc=%0d", cyc, e.ack_cyc);
                end
                cur_val = e.val;
                cur_dp  = e.dpm;
            end
        end else if (sb.size() > 0 && cyc >= sb[0].ack_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_ack cyc=%0d: got ack=%b, expected 1", cyc, ack);
            e = sb.pop_front();
            cur_val = e.val;
            cur_dp  = e.dpm;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != p; i++) tick();
    endtask

    // Drive a one-cycle load; the latest request before a boundary replaces an older one.
    task automatic drive_load(input logic [15:0] v, input logic [3:0] m);
        sb_t e;
        e.val     = v;
        e.dpm     = m;
        e.ack_cyc = (cyc / FRAME + 1) * FRAME;
        if (sb.size() > 0 && sb[$].ack_cyc == e.ack_cyc) void'(sb.pop_back());
        sb.push_back(e);
        load    = 1'b1;
        value   = v;
        dp_mask = m;
        tick();
        load    = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] an_e;
        logic [6:0] seg_e;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (an !== 4'hF || seg7 !== 7'h7F || dp !== 1'b1 || ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got an=%b seg7=%b dp=%b ack=%b, expected 1111 1111111 1 0",
                     an, seg7, dp, ack);
        end
        rst = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            an_e  = 4'hF;
            seg_e = 7'h7F;
            if (i >= 3 && i <= 8) begin an_e = 4'b1110; seg_e = 7'b1000000; end
            if (i == 11)          begin an_e = 4'b1101; seg_e = 7'b1000000; end
            n_checks++;
            if (an !== an_e || seg7 !== seg_e) begin
                n_fail++;
                $display("FAIL reset_release step %0d: got an=%b seg7=%b, expected an=%b seg7=%b",
                         i, an, seg7, an_e, seg_e);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        logic [6:0] codes [4];
        logic [3:0] an_e;
        int a_cyc, n_ack;
        codes = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
        wait_pos(13);
        drive_load(16'h1A3F, 4'h0);
        a_cyc = -1;
        n_ack = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (ack === 1'b1) begin
                n_ack++;
                if (a_cyc < 0) a_cyc = cyc;
            end
            for (int d = 0; d < 4; d++) begin
                if (a_cyc >= 0 && cyc == a_cyc + 3 + 8 * d) begin
                    an_e    = 4'hF;
                    an_e[d] = 1'b0;
                    n_checks++;
                    if (an !== an_e || seg7 !== codes[d]) begin
                        n_fail++;
                        $display("FAIL load_mid digit%0d: got an=%b seg7=%b, expected an=%b seg7=%b",
                                 d, an, seg7, an_e, codes[d]);
                    end
                end
            end
            if (a_cyc >= 0 && cyc == a_cyc + FRAME) break;
        end
        n_checks++;
        if (n_ack != 1 || a_cyc % FRAME != 0) begin
            n_fail++;
            $display("FAIL load_mid ack: got %0d acks first at cyc=%0d, expected 1 ack on a frame start",
                     n_ack, a_cyc);
        end
    endtask

    task automatic test_two_loads();
        logic [3:0] an_e;
        int a_cyc, n_ack;
        wait_pos(4);
        drive_load(16'h1111, 4'h0);
        wait_pos(10);
        drive_load(16'h2222, 4'h0);
        a_cyc = -1;
        n_ack = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (ack === 1'b1) begin
                n_ack++;
                if (a_cyc < 0) a_cyc = cyc;
            end
            for (int d = 0; d < 4; d++) begin
                if (a_cyc >= 0 && cyc == a_cyc + 3 + 8 * d) begin
                    an_e    = 4'hF;
                    an_e[d] = 1'b0;
                    n_checks++;
                    if (an !== an_e || seg7 !== 7'b0100100) begin
                        n_fail++;
                        $display("FAIL two_loads digit%0d: got an=%b seg7=%b, expected an=%b seg7=0100100",
                                 d, an, seg7, an_e);
                    end
                end
            end
            if (a_cyc >= 0 && cyc == a_cyc + FRAME) break;
        end
        n_checks++;
        if (n_ack != 1) begin
            n_fail++;
            $display("FAIL two_loads ack_count: got %0d, expected 1", n_ack);
        end
    endtask

    task automatic test_boundary_load();
        wait_pos(20);
        drive_load(16'h5555, 4'h0);
        wait_pos(31);
        drive_load(16'hBEEF, 4'h0);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary ack_next_cycle: got ack=%b, expected 1", ack);
        end
        tick();
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary ack_pulse_width: got ack=%b, expected 0", ack);
        end
        tick();
        tick();
        n_checks++;
        if (an !== 4'b1110 || seg7 !== 7'b0001110) begin
            n_fail++;
            $display("FAIL boundary digit0: got an=%b seg7=%b, expected an=1110 seg7=0001110", an, seg7);
        end
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (an !== 4'b1101 || seg7 !== 7'b0000110) begin
            n_fail++;
            $display("FAIL boundary digit1: got an=%b seg7=%b, expected an=1101 seg7=0000110", an, seg7);
        end
        wait_pos(0);
    endtask

    task automatic test_digit_en();
        int p, d;
        logic dp_e;
        digit_en = 4'b0101;
        wait_pos(6);
        drive_load(16'h4321, 4'b1000);
        wait_pos(0);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            p = (cyc - 1) % FRAME;
            d = p / 8;
            n_checks++;
            if (((d == 1 || d == 3) && an !== 4'hF) || dp !== 1'b1) begin
                n_fail++;
                $display("FAIL digit_en disabled slot p=%0d: got an=%b dp=%b, expected an=1111 for digits 1/3, dp=1",
                         p, an, dp);
            end
            if (p == 18) begin
                n_checks++;
                if (an !== 4'b1011 || seg7 !== 7'b0110000) begin
                    n_fail++;
                    $display("FAIL digit_en digit2 timing: got an=%b seg7=%b, expected an=1011 seg7=0110000",
                             an, seg7);
                end
            end
        end
        digit_en = 4'hF;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            p    = (cyc - 1) % FRAME;
            d    = p / 8;
            dp_e = (d == 3 && (p % 8) >= int'(BC)) ? 1'b0 : 1'b1;
            n_checks++;
            if (dp !== dp_e) begin
                n_fail++;
                $display("FAIL digit_en dp p=%0d: got dp=%b, expected %b", p, dp, dp_e);
            end
            if (p == 26) begin
                n_checks++;
                if (an !== 4'b0111 || seg7 !== 7'b0011001) begin
                    n_fail++;
                    $display("FAIL digit_en digit3: got an=%b seg7=%b, expected an=0111 seg7=0011001", an, seg7);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_ack;
        wait_pos(17);
        drive_load(16'h9876, 4'hF);
        wait_pos(20);
        rst = 1'b1;
        tick();
        n_checks++;
        if (an !== 4'hF || seg7 !== 7'h7F || dp !== 1'b1 || ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got an=%b seg7=%b dp=%b ack=%b, expected 1111 1111111 1 0",
                     an, seg7, dp, ack);
        end
        tick();
        rst   = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (ack === 1'b1) n_ack++;
            if (cyc == 3 || cyc == 27) begin
                n_checks++;
                if (an !== (cyc == 3 ? 4'b1110 : 4'b0111) || seg7 !== 7'b1000000 || dp !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_mid display cyc=%0d: got an=%b seg7=%b dp=%b, expected seg7=1000000 dp=1",
                             cyc, an, seg7, dp);
                end
            end
        end
        n_checks++;
        if (n_ack != 0) begin
            n_fail++;
            $display("FAIL reset_mid ack_count: got %0d, expected 0", n_ack);
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_mask  = '0;
        digit_en = 4'hF;
        test_reset();
        test_load_mid_frame();
        test_two_loads();
        test_boundary_load();
        test_digit_en();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected completion");
        $fatal(1);
    end

endmodule
